// File: rtl/trsq8_intc.sv
// trsq8_intc: vectored interrupt controller for the TRSQ8 8-bit core.
// Collects up to eight rising-edge interrupt sources, masks them in software,
// picks the lowest-index enabled pending source and walks it through
// request -> acknowledge -> return-from-interrupt with the core.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   src        interrupt source lines (rising edge requests service)
//   reg_we     register write strobe
//   reg_addr   register select: 0 PEND (W1C), 1 MASK, 2 STATUS (RO), 3 SWSET (W1S, reads 0)
//   reg_wdata  register write data
//   reg_rdata  register read data, combinational from reg_addr
//   irq        interrupt request to the core (1 while in REQ)
//   irq_vec    index of the source being requested or serviced
//   irq_ack    one-cycle pulse from the core when it vectors to the handler
//   irq_done   one-cycle pulse from the core on return-from-interrupt
module trsq8_intc #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src,
  input  logic               reg_we,
  input  logic [1:0]         reg_addr,
  input  logic [7:0]         reg_wdata,
  output logic [7:0]         reg_rdata,
  output logic               irq,
  output logic [2:0]         irq_vec,
  input  logic               irq_ack,
  input  logic               irq_done
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e             r_state, w_state_d;
  logic [NUM_SRC-1:0] r_src_d;
  logic [NUM_SRC-1:0] r_pend, w_pend_d;
  logic [NUM_SRC-1:0] r_mask, w_mask_d;
  logic [2:0]         r_vec, w_vec_d;
  logic               r_irq, w_irq_d;

  logic [NUM_SRC-1:0] w_rise, w_clr, w_set, w_req;
  logic [7:0]         w_pend8, w_mask8, w_ack_clr8;
  logic [2:0]         w_win;

  // Zero-extended copies so a 3-bit vector index is always in range.
  assign w_pend8 = 8'(r_pend);
  assign w_mask8 = 8'(r_mask);

  assign w_rise = src & ~r_src_d;
  assign w_clr  = (reg_we && reg_addr == 2'd0) ? reg_wdata[NUM_SRC-1:0] : '0;
  assign w_set  = (reg_we && reg_addr == 2'd3) ? reg_wdata[NUM_SRC-1:0] : '0;
  assign w_req  = r_pend & r_mask;

  assign w_mask_d = (reg_we && reg_addr == 2'd1) ? reg_wdata[NUM_SRC-1:0] : r_mask;

  // Sets are ORed in last so a same-cycle edge/SWSET beats W1C or ack clear.
  assign w_pend_d = (r_pend & ~w_clr & ~w_ack_clr8[NUM_SRC-1:0]) | w_rise | w_set;

  // Lowest index wins: scan downward so the last hit is the lowest.
  always_comb begin
    w_win = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_req[i]) w_win = 3'(i);
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_vec_d    = r_vec;
    w_ack_clr8 = 8'h00;
    case (r_state)
      StIdle: begin
        if (|w_req) begin
          w_vec_d   = w_win;
          w_state_d = StReq;
        end
      end
      StReq: begin
        // Software withdrew the request: give up before honouring an ack.
        if (!w_pend8[r_vec] || !w_mask8[r_vec]) begin
          w_state_d = StIdle;
        end else if (irq_ack) begin
          w_ack_clr8 = 8'h01 << r_vec;
          w_state_d  = StService;
        end
      end
      StService: begin
        if (irq_done) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_irq_d = (w_state_d == StReq);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_src_d <= '1;
      r_pend  <= '0;
      r_mask  <= '0;
      r_vec   <= 3'd0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_src_d <= src;
      r_pend  <= w_pend_d;
      r_mask  <= w_mask_d;
      r_vec   <= w_vec_d;
      r_irq   <= w_irq_d;
    end
  end

  always_comb begin
    reg_rdata = 8'h00;
    case (reg_addr)
      2'd0:    reg_rdata = w_pend8;
      2'd1:    reg_rdata = w_mask8;
      2'd2:    reg_rdata = {r_state == StService, r_state == StReq, 3'b000, r_vec};
      default: reg_rdata = 8'h00;
    endcase
  end

  assign irq     = r_irq;
  assign irq_vec = r_vec;

endmodule

// File: tb/tb_trsq8_intc.sv
module tb_trsq8_intc;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] src;
  logic       reg_we;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       irq;
  logic [2:0] irq_vec;
  logic       irq_ack;
  logic       irq_done;

  int n_vec = 0;
  int n_err = 0;

  trsq8_intc #(.NUM_SRC(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .src       (src),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq       (irq),
    .irq_vec   (irq_vec),
    .irq_ack   (irq_ack),
    .irq_done  (irq_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] srcv;
    logic       ack;
    logic       done;
    logic [1:0] caddr;
    logic       eirq;
    logic [2:0] evec;
    logic [7:0] erd;
  } vec_t;

  vec_t tbl[21];

  // Drive inputs for one rising edge, then return 1 time unit after it.
  task automatic step(input logic we, input logic [1:0] addr, input logic [7:0] wdata,
                      input logic [7:0] srcv, input logic ack, input logic done);
    @(negedge clk);
    reg_we    = we;
    reg_addr  = addr;
    reg_wdata = wdata;
    src       = srcv;
    irq_ack   = ack;
    irq_done  = done;
    @(posedge clk);
    #1;
    reg_we   = 1'b0;
    irq_ack  = 1'b0;
    irq_done = 1'b0;
  endtask

  task automatic check(input string nm, input logic [1:0] ca, input logic ei,
                       input logic [2:0] ev, input logic [7:0] er);
    reg_addr = ca;
    #1;
    n_vec++;
    if (irq !== ei || irq_vec !== ev || reg_rdata !== er) begin
      n_err++;
      $display("FAIL %s: got irq=%0b vec=%0d rdata[%0d]=%02h, required irq=%0b vec=%0d rdata=%02h",
               nm, irq, irq_vec, ca, reg_rdata, ei, ev, er);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // we addr wdata src ack done | caddr irq vec rdata
    // Single source, mask 0x01.
    tbl[0]  = '{1'b1, 2'd1, 8'h01, 8'h00, 1'b0, 1'b0, 2'd1, 1'b0, 3'd0, 8'h01};
    tbl[1]  = '{1'b0, 2'd0, 8'h00, 8'h01, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 8'h01};
    tbl[2]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd2, 1'b1, 3'd0, 8'h40};
    tbl[3]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 8'h00};
    tbl[4]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd2, 1'b0, 3'd0, 8'h80};
    tbl[5]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 2'd2, 1'b0, 3'd0, 8'h00};
    // Priority: sources 5 and 2 together.
    tbl[6]  = '{1'b1, 2'd1, 8'hFF, 8'h00, 1'b0, 1'b0, 2'd1, 1'b0, 3'd0, 8'hFF};
    tbl[7]  = '{1'b0, 2'd0, 8'h00, 8'h24, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 8'h24};
    tbl[8]  = '{1'b0, 2'd0, 8'h00, 8'h24, 1'b0, 1'b0, 2'd2, 1'b1, 3'd2, 8'h42};
    tbl[9]  = '{1'b0, 2'd0, 8'h00, 8'h24, 1'b1, 1'b0, 2'd0, 1'b0, 3'd2, 8'h20};
    tbl[10] = '{1'b0, 2'd0, 8'h00, 8'h24, 1'b0, 1'b1, 2'd2, 1'b0, 3'd2, 8'h02};
    tbl[11] = '{1'b0, 2'd0, 8'h00, 8'h24, 1'b0, 1'b0, 2'd2, 1'b1, 3'd5, 8'h45};
    tbl[12] = '{1'b0, 2'd0, 8'h00, 8'h24, 1'b1, 1'b0, 2'd0, 1'b0, 3'd5, 8'h00};
    tbl[13] = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 2'd2, 1'b0, 3'd5, 8'h05};
    // Masked source becomes enabled later.
    tbl[14] = '{1'b1, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0, 2'd1, 1'b0, 3'd5, 8'h00};
    tbl[15] = '{1'b0, 2'd0, 8'h00, 8'h08, 1'b0, 1'b0, 2'd0, 1'b0, 3'd5, 8'h08};
    tbl[16] = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd2, 1'b0, 3'd5, 8'h05};
    tbl[17] = '{1'b1, 2'd1, 8'h08, 8'h00, 1'b0, 1'b0, 2'd2, 1'b0, 3'd5, 8'h05};
    tbl[18] = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd2, 1'b1, 3'd3, 8'h43};
    tbl[19] = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 3'd3, 8'h00};
    tbl[20] = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 2'd2, 1'b0, 3'd3, 8'h03};

    reset_n   = 1'b0;
    src       = 8'h00;
    reg_we    = 1'b0;
    reg_addr  = 2'd0;
    reg_wdata = 8'h00;
    irq_ack   = 1'b0;
    irq_done  = 1'b0;
    #2;
    for (int a = 0; a < 4; a++) check("reset", 2'(a), 1'b0, 3'd0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].srcv, tbl[i].ack, tbl[i].done);
      check($sformatf("tbl[%0d]", i), tbl[i].caddr, tbl[i].eirq, tbl[i].evec, tbl[i].erd);
    end

    // W1C of the requested bit while in REQ withdraws the request.
    step(1'b1, 2'd1, 8'h02, 8'h00, 1'b0, 1'b0);
    step(1'b0, 2'd0, 8'h00, 8'h02, 1'b0, 1'b0);
    step(1'b0, 2'd0, 8'h00, 8'h02, 1'b0, 1'b0);
    check("w1c_req", 2'd2, 1'b1, 3'd1, 8'h41);
    step(1'b1, 2'd0, 8'h02, 8'h02, 1'b0, 1'b0);
    check("w1c_pend", 2'd0, 1'b1, 3'd1, 8'h00);
    step(1'b0, 2'd0, 8'h00, 8'h02, 1'b0, 1'b0);
    check("w1c_idle", 2'd2, 1'b0, 3'd1, 8'h01);

    // Vector stays frozen in REQ when a higher-priority source arrives.
    step(1'b1, 2'd1, 8'hFF, 8'h00, 1'b0, 1'b0);
    step(1'b0, 2'd0, 8'h00, 8'h02, 1'b0, 1'b0);
    step(1'b0, 2'd0, 8'h00, 8'h02, 1'b0, 1'b0);
    step(1'b0, 2'd0, 8'h00, 8'h03, 1'b0, 1'b0);
    check("freeze", 2'd2, 1'b1, 3'd1, 8'h41);
    step(1'b0, 2'd0, 8'h00, 8'h03, 1'b1, 1'b0);
    check("freeze_ack", 2'd0, 1'b0, 3'd1, 8'h01);
    step(1'b0, 2'd0, 8'h00, 8'h03, 1'b0, 1'b1);
    step(1'b0, 2'd0, 8'h00, 8'h03, 1'b0, 1'b0);
    check("freeze_next", 2'd2, 1'b1, 3'd0, 8'h40);
    step(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    step(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1);

    // Line held high through reset release must not trigger; SWSET then does.
    @(negedge clk);
    reset_n = 1'b0;
    src     = 8'h10;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 2'd0, 8'h00, 8'h10, 1'b0, 1'b0);
    check("held_src", 2'd0, 1'b0, 3'd0, 8'h00);
    step(1'b1, 2'd1, 8'h10, 8'h10, 1'b0, 1'b0);
    step(1'b1, 2'd3, 8'h10, 8'h10, 1'b0, 1'b0);
    check("swset_rd0", 2'd3, 1'b0, 3'd0, 8'h00);
    step(1'b0, 2'd0, 8'h00, 8'h10, 1'b0, 1'b0);
    check("swset_irq", 2'd2, 1'b1, 3'd4, 8'h44);
    step(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    check("svc", 2'd2, 1'b0, 3'd4, 8'h84);

    // Asynchronous reset during SERVICE, away from any clock edge.
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_mask", 2'd1, 1'b0, 3'd0, 8'h00);
    check("rst_stat", 2'd2, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    check("ack_idle", 2'd2, 1'b0, 3'd0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trsq8_intc.md
# trsq8_intc

Vectored interrupt controller for the TRSQ8 8-bit core. It collects up to eight edge-triggered interrupt sources and applies a software mask and fixed priority. It drives the core's single `irq` input and sequences each request through assert, acknowledge and return-from-interrupt. It sits between peripheral interrupt lines and the TRSQ8 core and is configured through a small 4-register bus slave.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources; legal range 1..8.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `src` in NUM_SRC: interrupt source lines, synchronous to `clk`; rising edge requests service.
- `reg_we` in 1: register write strobe, one cycle per write.
- `reg_addr` in 2: register select.
- `reg_wdata` in 8: write data.
- `reg_rdata` out 8: read data, combinational from `reg_addr`.
- `irq` out 1: interrupt request to the TRSQ8 core.
- `irq_vec` out 3: index of the source being requested or serviced.
- `irq_ack` in 1: one-cycle pulse from the core when it vectors to the handler.
- `irq_done` in 1: one-cycle pulse from the core on return-from-interrupt.

## Operation
- Edge detect: `src_d` registers `src`. A source's `pend[i]` sets at the edge where `src[i]=1` and `src_d[i]=0`. `src_d` resets to all ones, so a line already high at reset release does not trigger.
- Registers:
  - 0 PEND: read gives pending bits; write-1-to-clear.
  - 1 MASK: read/write; 1 = enabled.
  - 2 STATUS: read only, `{state==SERVICE, state==REQ, 3'b0, irq_vec}`.
  - 3 SWSET: write-1-sets pending bits; reads 0.
  - Bits at or above NUM_SRC read 0 and ignore writes.
- Simultaneous set and clear of the same `pend` bit in one cycle: set wins.
- Priority: the lowest index among `pend & mask` wins.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if `pend & mask != 0`, latch the winning index into `irq_vec` and go to REQ.
  - REQ: `irq=1`. If `pend[irq_vec]` or `mask[irq_vec]` is 0 (cleared by software), go to IDLE. Otherwise, on `irq_ack`, clear `pend[irq_vec]` and go to SERVICE. `irq_vec` stays frozen in REQ even if a higher-priority source becomes pending.
  - SERVICE: `irq=0`, `irq_vec` held. On `irq_done`, go to IDLE. No nesting: new pendings wait.
- `irq_ack` outside REQ and `irq_done` outside SERVICE are ignored.
- If an ack and a same-bit source edge occur in the same cycle, set wins: the bit stays pending and is serviced again later.

## Timing
- Reset values: `irq=0`, `irq_vec=0`, state IDLE, PEND=0, MASK=0, `src_d` all ones; `reg_rdata` follows the reset register contents.
- `irq` is registered: it is 1 exactly when the state is REQ.
- Latency with the source masked-in: `src` first sampled high at edge k gives `pend` set after k and `irq=1` after k+1, i.e. 2 cycles.
- Ack: `irq_ack` sampled at edge j gives `irq=0` and the pend bit cleared after j.
- Done: `irq_done` at edge m gives IDLE after m. If another request is pending, `irq=1` after m+1.
- SWSET in IDLE: written at edge k, `irq=1` after k+1.
- Software clear or mask while in REQ: `irq` drops one cycle after the write edge.
- Reset asserted at any point forces all reset values immediately, including mid-REQ or mid-SERVICE.

## Test plan
- MASK=0x01, then pulse `src[0]` → `irq=1` two cycles after the edge with `irq_vec=0`; ack → `irq=0`, PEND=0x00; done → STATUS=0x00.
- MASK=0xFF, then raise `src[5]` and `src[2]` on the same edge → `irq_vec=2`; after ack and done → `irq` reasserts with `irq_vec=5`.
- MASK=0x00, then pulse `src[3]` → PEND reads 0x08, `irq` stays 0; write MASK=0x08 → `irq=1` next cycle with `irq_vec=3`.
- In REQ for source 1, write PEND=0x02 (W1C) → `irq` drops the next cycle and the state returns to IDLE. In a second run, while in REQ for source 1, raise `src[0]` → `irq_vec` stays 1.
- Hold `src[4]=1` through reset release → no pend. Write SWSET=0x10 with MASK=0x10 → `irq=1` two edges later with `irq_vec=4`.
- Assert `reset_n=0` during SERVICE → `irq=0`, MASK=0, STATUS=0 immediately. An `irq_ack` pulse in IDLE → no state change.
